// File: rtl/keccak_chi_sequencer_if.sv
// State/round handshake bundle for the sliced Keccak chi+iota engine.
// The engine side uses the slave modport; the producer/consumer side uses master.
interface keccak_chi_sequencer_if;
  logic          in_valid;
  logic          in_ready;
  logic [0:1599] in_state;
  logic [4:0]    in_rnd;
  logic          out_valid;
  logic          out_ready;
  logic [0:1599] out_state;

  modport master (
    output in_valid, in_state, in_rnd, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_rnd, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/keccak_chi_sequencer.sv
// Sliced Keccak-f[1600] chi+iota engine: walks eight 8-bit lane slices, MSB byte
// first, one per cycle, then presents the full state on a valid/ready handshake.
module keccak_chi_sequencer #(
  parameter int NSUB = 8,
  parameter int RMAX = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keccak_chi_sequencer_if.slave  bus,
  output logic                   busy,
  output logic [4:0]             rnd_cnt,
  output logic [2:0]             sub_rnd_cnt,
  output logic                   pre_rnd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_e;

  localparam logic [2:0] LAST_SUB = 3'(NSUB - 1);

  fsm_e          fsm;
  logic [0:1599] work;
  logic [0:1599] work_next;
  logic [0:1599] out_state_q;
  logic          out_valid_q;
  logic          accept;
  logic [6:0]    rc_bits;
  logic [63:0]   rc_full;
  logic [7:0]    rc_byte;
  logic [7:0]    slice_in  [25];
  logic [7:0]    slice_out [25];

  assign bus.in_ready  = (fsm == S_IDLE) || ((fsm == S_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;

  // Round constants only ever set bits {63,31,15,7,3,1,0}; stored in that order.
  // NOTE: every signal driven in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rc_bits = '0;
    if (rnd_cnt != '0 && int'(rnd_cnt) <= RMAX) begin
      case (rnd_cnt)
        5'd1:  rc_bits = 7'b0000001;
        5'd2:  rc_bits = 7'b0011010;
        5'd3:  rc_bits = 7'b1011110;
        5'd4:  rc_bits = 7'b1110000;
        5'd5:  rc_bits = 7'b0011111;
        5'd6:  rc_bits = 7'b0100001;
        5'd7:  rc_bits = 7'b1111001;
        5'd8:  rc_bits = 7'b1010101;
        5'd9:  rc_bits = 7'b0001110;
        5'd10: rc_bits = 7'b0001100;
        5'd11: rc_bits = 7'b0110101;
        5'd12: rc_bits = 7'b0100110;
        5'd13: rc_bits = 7'b0111111;
        5'd14: rc_bits = 7'b1001111;
        5'd15: rc_bits = 7'b1011101;
        5'd16: rc_bits = 7'b1010011;
        5'd17: rc_bits = 7'b1010010;
        5'd18: rc_bits = 7'b1001000;
        5'd19: rc_bits = 7'b0010110;
        5'd20: rc_bits = 7'b1100110;
        5'd21: rc_bits = 7'b1111001;
        5'd22: rc_bits = 7'b1011000;
        5'd23: rc_bits = 7'b0100001;
        5'd24: rc_bits = 7'b1110100;
        default: rc_bits = '0;
      endcase
    end
  end

  always_comb begin
    rc_full     = '0;
    rc_full[63] = rc_bits[6];
    rc_full[31] = rc_bits[5];
    rc_full[15] = rc_bits[4];
    rc_full[7]  = rc_bits[3];
    rc_full[3]  = rc_bits[2];
    rc_full[1]  = rc_bits[1];
    rc_full[0]  = rc_bits[0];
    rc_byte     = rc_full[63 - 8*int'(sub_rnd_cnt) -: 8];
  end

  assign pre_rnd = rc_bits[6];

  // Chi on the current byte slice of all 25 lanes, iota folded into lane 0.
  always_comb begin
    work_next = work;
    for (int i = 0; i < 25; i++) begin
      slice_in[i] = work[64*i + 8*int'(sub_rnd_cnt) +: 8];
    end
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        slice_out[x + 5*y] = slice_in[x + 5*y] ^
                             (~slice_in[(x + 1) % 5 + 5*y] & slice_in[(x + 2) % 5 + 5*y]);
      end
    end
    slice_out[0] = slice_out[0] ^ rc_byte;
    for (int i = 0; i < 25; i++) begin
      work_next[64*i + 8*int'(sub_rnd_cnt) +: 8] = slice_out[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the wide state registers are reset too, so an aborted job leaves no
  // stale data visible on out_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= S_IDLE;
      work        <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      rnd_cnt     <= '0;
      sub_rnd_cnt <= '0;
    end else begin
      case (fsm)
        S_RUN: begin
          work <= work_next;
          if (sub_rnd_cnt == LAST_SUB) begin
            fsm         <= S_DONE;
            out_state_q <= work_next;
            out_valid_q <= 1'b1;
            busy        <= 1'b0;
            sub_rnd_cnt <= '0;
          end else begin
            sub_rnd_cnt <= sub_rnd_cnt + 3'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            fsm         <= S_IDLE;
          end
        end
        default: ;
      endcase
      // An accept in DONE overrides the return to IDLE for a bubble-free restart.
      if (accept) begin
        fsm         <= S_RUN;
        work        <= bus.in_state;
        rnd_cnt     <= bus.in_rnd;
        sub_rnd_cnt <= '0;
        busy        <= 1'b1;
      end
    end
  end

endmodule
